// File: rtl/rv_pkg.sv
// Shared definitions for the pipelined immediate generator: format encodings,
// default widths and the skid-buffer state type.
package rv_pkg;

   localparam int XLEN_DEF = 32;
   localparam int TAGW_DEF = 5;

   typedef enum logic [2:0] {
      IMM_I     = 3'b000,
      IMM_S     = 3'b001,
      IMM_B     = 3'b010,
      IMM_U     = 3'b011,
      IMM_J     = 3'b100,
      IMM_Z     = 3'b101,
      IMM_SHAMT = 3'b110,
      IMM_RSV   = 3'b111
   } imm_sel_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   // Buffered entry at the default widths; the top declares the same layout
   // sized by its own parameters.
   typedef struct packed {
      logic [XLEN_DEF-1:0] imm;
      logic [TAGW_DEF-1:0] tag;
      logic                err;
   } imm_entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign/zero extension to XLEN.
module imm_extract
   import rv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [31:0]     instin,
   input  logic [2:0]      imgsel,
   output logic [XLEN-1:0] imm,
   output logic            err
);

   // The opcode field never contributes to any immediate.
   logic unused_opcode;
   assign unused_opcode = ^instin[6:0];

   always_comb begin
      imm = '0;
      err = 1'b0;
      case (imm_sel_e'(imgsel))
         IMM_I: imm = XLEN'($signed(instin[31:20]));
         IMM_S: imm = XLEN'($signed({instin[31:25], instin[11:7]}));
         IMM_B: imm = XLEN'($signed({instin[31], instin[7], instin[30:25],
                                     instin[11:8], 1'b0}));
         IMM_U: imm = XLEN'($signed({instin[31:12], 12'b0}));
         IMM_J: imm = XLEN'($signed({instin[31], instin[19:12], instin[20],
                                     instin[30:21], 1'b0}));
         IMM_Z: imm = XLEN'(instin[19:15]);
         IMM_SHAMT: begin
            if (XLEN == 64) imm = XLEN'(instin[25:20]);
            else            imm = XLEN'(instin[24:20]);
         end
         IMM_RSV: err = 1'b1;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a registered valid/ready output stage backed by a
// 2-entry skid buffer; a sideband tag travels with each immediate.
module imm_gen_pipe
   import rv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int TAGW = TAGW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instin,
   input  logic [2:0]      imgsel,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imout,
   output logic [TAGW-1:0] out_tag,
   output logic            out_err
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [TAGW-1:0] tag;
      logic            err;
   } entry_t;

   logic [XLEN-1:0] ext_imm;
   logic            ext_err;
   entry_t          new_entry;

   skid_state_e state_q, state_d;
   entry_t      main_q, main_d;
   entry_t      skid_q, skid_d;
   logic        out_valid_q, out_valid_d;
   logic        in_ready_q, in_ready_d;
   logic        in_fire, out_fire;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instin (instin),
      .imgsel (imgsel),
      .imm    (ext_imm),
      .err    (ext_err)
   );

   assign new_entry = '{imm: ext_imm, tag: in_tag, err: ext_err};
   assign in_fire   = in_valid && in_ready_q;
   assign out_fire  = out_valid_q && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_d  = new_entry;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = new_entry;
               end else if (in_fire) begin
                  skid_d  = new_entry;
                  state_d = ST_FULL;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a drain can happen.
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign imout     = main_q.imm;
   assign out_tag   = main_q.tag;
   assign out_err   = main_q.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against a FIFO-level reference model.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] instin = '0;
   logic [2:0]  imgsel = '0;
   logic [4:0]  in_tag = '0;

   logic        in_ready32, out_valid32, out_err32;
   logic [31:0] imout32;
   logic [4:0]  out_tag32;
   logic        in_ready64, out_valid64, out_err64;
   logic [63:0] imout64;
   logic [4:0]  out_tag64;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] imm32;
      logic [63:0] imm64;
      logic [4:0]  tag;
      logic        err;
   } exp_t;

   exp_t mq[$];
   logic exp_in_ready = 1'b1;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAGW(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready32), .instin(instin), .imgsel(imgsel), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready), .imout(imout32),
      .out_tag(out_tag32), .out_err(out_err32)
   );

   imm_gen_pipe #(.XLEN(64), .TAGW(5)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready64), .instin(instin), .imgsel(imgsel), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .imout(imout64),
      .out_tag(out_tag64), .out_err(out_err64)
   );

   // Reference immediate from the format rules using integer arithmetic.
   function automatic logic [63:0] ref_imm(input logic [31:0] inst,
                                           input logic [2:0] sel, input int xlen);
      longint v;
      longint one = 1;
      case (sel)
         3'd0: begin v = longint'(inst[31:20]); if (v >= 2048) v -= 4096; end
         3'd1: begin v = longint'({inst[31:25], inst[11:7]}); if (v >= 2048) v -= 4096; end
         3'd2: begin
            v = longint'({inst[31], inst[7], inst[30:25], inst[11:8]}) * 2;
            if (v >= 4096) v -= 8192;
         end
         3'd3: begin
            v = longint'(inst[31:12]) * 4096;
            if (v >= (one << 31)) v -= (one << 32);
         end
         3'd4: begin
            v = longint'({inst[31], inst[19:12], inst[20], inst[30:21]}) * 2;
            if (v >= (one << 20)) v -= (one << 21);
         end
         3'd5: v = longint'(inst[19:15]);
         3'd6: v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
         default: v = 0;
      endcase
      if (xlen == 32) return {32'h0, v[31:0]};
      return 64'(v);
   endfunction

   function automatic exp_t mk(input logic [31:0] inst, input logic [2:0] sel,
                               input logic [4:0] tag);
      exp_t e;
      e.imm32 = ref_imm(inst, sel, 32);
      e.imm64 = ref_imm(inst, sel, 64);
      e.tag   = tag;
      e.err   = (sel == 3'd7);
      return e;
   endfunction

   // Advance one clock and update the model with the transfers that happened.
   task automatic step();
      bit inf, outf;
      inf  = in_valid && exp_in_ready;
      outf = (mq.size() != 0) && out_ready;
      @(posedge clk);
      #1;
      if (flush) mq.delete();
      else begin
         if (outf) void'(mq.pop_front());
         if (inf) mq.push_back(mk(instin, imgsel, in_tag));
      end
      exp_in_ready = (mq.size() < 2);
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (out_valid32 !== 1'b0 || imout32 !== 32'h0 || out_tag32 !== 5'h0 || out_err32 !== 1'b0)
         begin failures++; $display("FAIL reset32 got v=%0b imm=%h tag=%0d err=%0b want all 0",
                                    out_valid32, imout32, out_tag32, out_err32); end
      checks++;
      if (out_valid64 !== 1'b0 || imout64 !== 64'h0 || out_tag64 !== 5'h0 || out_err64 !== 1'b0)
         begin failures++; $display("FAIL reset64 got v=%0b imm=%h want all 0", out_valid64, imout64); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      checks++;
      if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1)
         begin failures++; $display("FAIL reset_in_ready got %0b/%0b want 1", in_ready32, in_ready64); end
   endtask

   task automatic test_formats();
      logic [31:0] vi [7];
      logic [2:0]  vs [7];
      logic [31:0] e32 [7];
      logic [63:0] e64 [7];
      vi  = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h008000EF,
              32'h800000B7, 32'h000FD073, 32'h02500013};
      vs  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6};
      e32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000008,
              32'h80000000, 32'd31, 32'd5};
      e64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
              64'h8, 64'hFFFFFFFF80000000, 64'd31, 64'd37};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; instin = vi[i]; imgsel = vs[i]; in_tag = 5'(i + 10);
         step();
         in_valid = 1'b0;
         checks++;
         if (out_valid32 !== 1'b1 || imout32 !== e32[i] || out_err32 !== 1'b0 || out_tag32 !== 5'(i + 10))
            begin failures++; $display("FAIL fmt32[%0d] got v=%0b imm=%h err=%0b tag=%0d want imm=%h",
                                       i, out_valid32, imout32, out_err32, out_tag32, e32[i]); end
         checks++;
         if (out_valid64 !== 1'b1 || imout64 !== e64[i] || out_err64 !== 1'b0)
            begin failures++; $display("FAIL fmt64[%0d] got imm=%h err=%0b want %h",
                                       i, imout64, out_err64, e64[i]); end
         $display("fmt sel=%0d inst=%h imm32=%h imm64=%h", vs[i], vi[i], imout32, imout64);
         step();
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] obs[$];
      bit acc;
      out_ready = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         in_valid = 1'b1; instin = $urandom; imgsel = 3'd0; in_tag = 5'(k);
         step();
      end
      checks++;
      if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0)
         begin failures++; $display("FAIL bp_full_ready got %0b/%0b want 0", in_ready32, in_ready64); end
      in_tag = 5'd3; instin = $urandom;
      repeat (2) step();
      checks++;
      if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || out_tag32 !== 5'd1)
         begin failures++; $display("FAIL bp_hold got rdy=%0b v=%0b tag=%0d want 0/1/1",
                                    in_ready32, out_valid32, out_tag32); end
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (out_valid32 && out_ready) obs.push_back(out_tag32);
         acc = in_valid && exp_in_ready;
         step();
         if (acc) in_valid = 1'b0;
         if (obs.size() == 3 && mq.size() == 0) break;
      end
      checks++;
      if (obs.size() != 3)
         begin failures++; $display("FAIL bp_count got %0d outputs want 3", obs.size()); end
      else for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs[k] !== 5'(k + 1))
            begin failures++; $display("FAIL bp_order[%0d] got tag %0d want %0d", k, obs[k], k + 1); end
      end
      $display("backpressure drained %0d tags", obs.size());
   endtask

   task automatic test_reserved_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; instin = $urandom; imgsel = 3'd7; in_tag = 5'd9;
      step();
      checks++;
      if (out_valid32 !== 1'b1 || imout32 !== 32'h0 || out_err32 !== 1'b1 || imout64 !== 64'h0 || out_err64 !== 1'b1)
         begin failures++; $display("FAIL reserved got v=%0b imm=%h err=%0b want 1/0/1",
                                    out_valid32, imout32, out_err32); end
      imgsel = 3'd1; instin = $urandom; in_tag = 5'd10;
      step();
      checks++;
      if (in_ready32 !== 1'b0)
         begin failures++; $display("FAIL flush_pre_full got in_ready=%0b want 0", in_ready32); end
      flush = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0)
         begin failures++; $display("FAIL flush got v=%0b rdy=%0b want 0/1", out_valid32, in_ready32); end
      step();
      checks++;
      if (out_valid32 !== 1'b0)
         begin failures++; $display("FAIL flush_discard got v=%0b want 0", out_valid32); end
      $display("reserved+flush done");
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; instin = 32'hFFF00093; imgsel = 3'd0; in_tag = 5'd7;
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid32 !== 1'b0 || imout32 !== 32'h0 || out_tag32 !== 5'h0 || out_err32 !== 1'b0 || imout64 !== 64'h0)
         begin failures++; $display("FAIL async_reset got v=%0b imm=%h tag=%0d want 0",
                                    out_valid32, imout32, out_tag32); end
      #2 rst_n = 1'b1;
      mq.delete();
      exp_in_ready = 1'b1;
      step();
      checks++;
      if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1)
         begin failures++; $display("FAIL async_reset_after got v=%0b rdy=%0b want 0/1", out_valid32, in_ready32); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         instin    = $urandom;
         imgsel    = 3'($urandom_range(0, 7));
         in_tag    = 5'($urandom_range(0, 31));
         step();
         checks++;
         if (out_valid32 !== (mq.size() != 0) || out_valid64 !== (mq.size() != 0))
            begin failures++; $display("FAIL rnd_valid[%0d] got %0b/%0b want %0b",
                                       n, out_valid32, out_valid64, mq.size() != 0); end
         checks++;
         if (in_ready32 !== exp_in_ready || in_ready64 !== exp_in_ready)
            begin failures++; $display("FAIL rnd_ready[%0d] got %0b/%0b want %0b",
                                       n, in_ready32, in_ready64, exp_in_ready); end
         if (mq.size() != 0) begin
            checks++;
            if (imout32 !== mq[0].imm32[31:0] || out_tag32 !== mq[0].tag || out_err32 !== mq[0].err)
               begin failures++; $display("FAIL rnd_data32[%0d] got imm=%h tag=%0d err=%0b want imm=%h tag=%0d err=%0b",
                                          n, imout32, out_tag32, out_err32, mq[0].imm32[31:0], mq[0].tag, mq[0].err); end
            checks++;
            if (imout64 !== mq[0].imm64 || out_tag64 !== mq[0].tag || out_err64 !== mq[0].err)
               begin failures++; $display("FAIL rnd_data64[%0d] got imm=%h tag=%0d want imm=%h tag=%0d",
                                          n, imout64, out_tag64, mq[0].imm64, mq[0].tag); end
         end
      end
      flush = 1'b0;
      in_valid = 1'b0;
      $display("random phase done");
   endtask

   initial begin
      test_reset();
      test_formats();
      test_backpressure();
      test_reserved_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the decode-stage immediate generator.
- Extracts and sign- or zero-extends immediates to XLEN for formats I, S, B, U, J, Z (CSR uimm) and SHAMT.
- Sits between fetch/decode and the operand mux. Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode can stall without recomputing.
- A user tag (PC, rd, etc.) travels alongside each immediate.

Parameters:
- XLEN, 32, output width; legal values 32 or 64.
- TAGW, 5, width of the sideband tag passed through with each immediate.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept this cycle.
- instin  in  32  raw instruction word.
- imgsel  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 110 SHAMT, 111 reserved.
- in_tag  in  TAGW  sideband.
- out_valid  out  1  immediate available.
- out_ready  in  1  consumer accepts.
- imout  out  XLEN  extended immediate.
- out_tag  out  TAGW  tag matching imout.
- out_err  out  1  imgsel was 111 for this entry.

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries invalid; out_valid=0, imout=0, out_tag=0, out_err=0; in_ready=1 from the first cycle after release.
- Format rules. Let s = instin[31].
  - I: sext(instin[31:20]).
  - S: sext({instin[31:25], instin[11:7]}).
  - B: sext({instin[31], instin[7], instin[30:25], instin[11:8], 1'b0}).
  - U: sext({instin[31:12], 12'b0}); with XLEN=64, bits 63:32 = s.
  - J: sext({instin[31], instin[19:12], instin[20], instin[30:21], 1'b0}).
  - Z: zext(instin[19:15]).
  - SHAMT: zext(instin[24:20]) for XLEN=32; zext(instin[25:20]) for XLEN=64.
  - 111: imout=0, out_err=1. Every other format gives out_err=0.
- Extension is computed combinationally, then captured. It is never recomputed from instin after capture.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Once out_valid is asserted, it holds with imout/out_tag/out_err stable until the output transfer.
- Structure: main register plus skid register. States are EMPTY (0 entries), ONE (main valid), FULL (main + skid valid).
  - in_ready = (state != FULL). This is registered; no combinational path from out_ready to in_ready.
  - EMPTY + input transfer -> ONE. Latency is 1 cycle: data accepted at edge N appears on imout after edge N.
  - ONE + input transfer + output transfer -> ONE; main register is loaded with the new data.
  - ONE + input transfer, no output transfer -> FULL; new data goes to skid.
  - ONE + output transfer only -> EMPTY.
  - FULL + output transfer -> ONE; skid moves to main. in_ready is 0, so no input transfer is possible this cycle.
- Ordering is strictly FIFO; throughput is 1/cycle when out_ready is held high.
- flush: next state is EMPTY regardless of in_valid/out_ready. A coincident input is discarded. out_valid=0 the following cycle. flush has priority over every other event.
- Reset mid-operation: all in-flight entries are lost; no partial output.
- imout/out_tag hold their last value when out_valid=0. Consumers must ignore them then.

Decomposition:
- Shared package (rv_pkg):
  - imgsel encodings IMM_I..IMM_SHAMT, IMM_RSV.
  - XLEN default.
  - A typedef for the buffered entry {imm, tag, err}.
- Sub-module imm_extract: purely combinational, instin + imgsel -> {imm, err}, parametrised by XLEN.
- The top module holds the 2-entry skid control and registers.

Test Plan:
- I, XLEN=32: instin=0xFFF00093, imgsel=000, out_ready=1 -> one cycle later imout=0xFFFFFFFF, out_err=0.
- S: instin=0xFE20AE23, imgsel=001 -> imout=0xFFFFFFFC.
- B: instin=0xFE000CE3, imgsel=010 -> imout=0xFFFFFFF8.
- J: instin=0x008000EF, imgsel=100 -> imout=0x00000008.
- U, XLEN=64: instin=0x800000B7, imgsel=011 -> imout=0xFFFFFFFF80000000.
- Z: instin=0x000FD073, imgsel=101 -> imout=31.
- Backpressure: 3 back-to-back inputs with tags 1,2,3 and out_ready=0.
  - Expect in_ready=0 after the 2nd accept; the 3rd input is held.
  - Raise out_ready: tags emerge 1,2,3 in order, none duplicated or lost.
- Reserved + flush:
  - imgsel=111 -> imout=0, out_err=1.
  - Then with FULL state, assert flush -> out_valid=0 next cycle, in_ready=1.
  - Async rst_n pulse mid-stream -> all outputs 0 immediately.
